// File: rtl/data_memory_responder.sv
// Multi-cycle data-memory responder for the pipeline M stage: one request at a time,
// WAIT_CYCLES wait states, byte-lane stores and sign/zero-extended loads.
module data_memory_responder #(
  parameter int ADDR_WIDTH  = 10,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic        we,
  input  logic [1:0]  size,
  input  logic        unsigned_ld,
  input  logic [31:0] address,
  input  logic [31:0] write_data,
  output logic [31:0] read_data,
  output logic        ready,
  output logic        error,
  output logic        busy
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);

  state_t                r_state;
  state_t                w_state_nxt;
  logic [3:0]            r_cnt;
  logic                  r_we;
  logic [1:0]            r_size;
  logic                  r_unsigned;
  logic [ADDR_WIDTH+1:0] r_addr;
  logic [31:0]           r_wdata;
  logic [31:0]           r_rdata;
  logic                  r_error;
  logic                  r_ready;
  logic [31:0]           r_mem [0:(2**ADDR_WIDTH)-1];

  logic                  w_access;
  logic                  w_mis;
  logic                  w_mem_we;
  logic [ADDR_WIDTH-1:0] w_idx;
  logic [31:0]           w_word;
  logic [31:0]           w_wword;
  logic [31:0]           w_load;
  logic                  w_unused_addr;

  function automatic logic misaligned(input logic [1:0] sz, input logic [1:0] a);
    logic res;
    case (sz)
      2'b00:   res = 1'b0;
      2'b01:   res = a[0];
      2'b10:   res = (a != 2'b00);
      default: res = 1'b1;
    endcase
    return res;
  endfunction

  function automatic logic [31:0] extract_load(input logic [31:0] word, input logic [1:0] sz,
                                               input logic [1:0] a, input logic uns);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] res;
    b = word[{a, 3'b000} +: 8];
    h = a[1] ? word[31:16] : word[15:0];
    case (sz)
      2'b00:   res = uns ? {24'h000000, b} : {{24{b[7]}}, b};
      2'b01:   res = uns ? {16'h0000, h} : {{16{h[15]}}, h};
      default: res = word;
    endcase
    return res;
  endfunction

  function automatic logic [31:0] merge_store(input logic [31:0] old, input logic [31:0] wd,
                                              input logic [1:0] sz, input logic [1:0] a);
    logic [31:0] res;
    res = old;
    case (sz)
      2'b00:   res[{a, 3'b000} +: 8] = wd[7:0];
      2'b01:   res[{a[1], 4'b0000} +: 16] = wd[15:0];
      2'b10:   res = wd;
      default: res = old;
    endcase
    return res;
  endfunction

  // Upper address bits only alias the array, so they are intentionally dropped.
  assign w_unused_addr = ^address[31:ADDR_WIDTH+2];

  assign w_access = (r_state == S_WAIT) && (r_cnt == 4'd0);
  assign w_mis    = misaligned(r_size, r_addr[1:0]);
  assign w_idx    = r_addr[ADDR_WIDTH+1:2];
  assign w_word   = r_mem[w_idx];
  assign w_mem_we = w_access && r_we && !w_mis;
  assign w_wword  = merge_store(w_word, r_wdata, r_size, r_addr[1:0]);
  assign w_load   = (r_we || w_mis) ? 32'h00000000
                                    : extract_load(w_word, r_size, r_addr[1:0], r_unsigned);

  assign read_data = r_rdata;
  assign ready     = r_ready;
  assign error     = r_error;

  // Next-state and stall decode; busy drops in RESP so the pipeline advances with ready.
  always_comb begin
    w_state_nxt = r_state;
    busy        = 1'b0;
    case (r_state)
      S_IDLE: begin
        busy = req;
        if (req) begin
          w_state_nxt = S_WAIT;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_WAIT: begin
        busy = 1'b1;
        if (r_cnt == 4'd0) begin
          w_state_nxt = S_RESP;
        end else begin
          w_state_nxt = S_WAIT;
        end
      end
      S_RESP:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Control, request latch and registered response.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= S_IDLE;
      r_cnt      <= 4'd0;
      r_we       <= 1'b0;
      r_size     <= 2'b00;
      r_unsigned <= 1'b0;
      r_addr     <= '0;
      r_wdata    <= 32'h00000000;
      r_rdata    <= 32'h00000000;
      r_error    <= 1'b0;
      r_ready    <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      case (r_state)
        S_IDLE: begin
          if (req) begin
            r_we       <= we;
            r_size     <= size;
            r_unsigned <= unsigned_ld;
            r_addr     <= address[ADDR_WIDTH+1:0];
            r_wdata    <= write_data;
            r_cnt      <= WAIT_INIT;
          end
        end
        S_WAIT: begin
          if (r_cnt != 4'd0) begin
            r_cnt <= r_cnt - 4'd1;
          end else begin
            r_rdata <= w_load;
            r_error <= w_mis;
            r_ready <= 1'b1;
          end
        end
        S_RESP: begin
          r_ready <= 1'b0;
          r_rdata <= 32'h00000000;
          r_error <= 1'b0;
        end
        default: r_ready <= 1'b0;
      endcase
    end
  end

  // Array contents are deliberately not reset.
  always_ff @(posedge clk) begin
    if (w_mem_we) begin
      r_mem[w_idx] <= w_wword;
    end
  end

endmodule

// File: tb/tb_data_memory_responder.sv
// Self-checking bench for data_memory_responder: directed steps plus randomized
// accesses checked against a word-array reference model.
module tb_data_memory_responder;

  localparam int AW = 10;
  localparam int WC = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic        req;
  logic        we;
  logic [1:0]  size;
  logic        unsigned_ld;
  logic [31:0] address;
  logic [31:0] write_data;
  logic [31:0] read_data;
  logic        ready;
  logic        error;
  logic        busy;

  int checks = 0;
  int passes = 0;
  logic [31:0] ref_mem [0:(2**AW)-1];
  logic [31:0] last_rd;
  logic        last_er;

  always #5 clk = ~clk;

  data_memory_responder #(.ADDR_WIDTH(AW), .WAIT_CYCLES(WC)) dut (
    .clk(clk), .reset(reset), .req(req), .we(we), .size(size),
    .unsigned_ld(unsigned_ld), .address(address), .write_data(write_data),
    .read_data(read_data), .ready(ready), .error(error), .busy(busy)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  // Reference: byte-addressed memory rules applied to a plain word array.
  function automatic void ref_access(input logic w, input logic [1:0] sz, input logic u,
                                     input logic [31:0] a, input logic [31:0] wd,
                                     output logic [31:0] rd, output logic er);
    int unsigned idx;
    int unsigned off;
    logic [31:0] word;
    logic [31:0] v;
    idx  = (a / 4) % (2**AW);
    off  = a % 4;
    word = ref_mem[idx];
    er   = (sz == 2'd3) || (sz == 2'd1 && (off % 2) != 0) || (sz == 2'd2 && off != 0);
    rd   = 32'd0;
    if (!er) begin
      if (w) begin
        if (sz == 2'd0)
          word = (word & ~(32'h000000FF << (8 * off))) | ({24'd0, wd[7:0]} << (8 * off));
        else if (sz == 2'd1)
          word = (word & ~(32'h0000FFFF << (8 * off))) | ({16'd0, wd[15:0]} << (8 * off));
        else
          word = wd;
        ref_mem[idx] = word;
      end else begin
        if (sz == 2'd0) begin
          v  = (word >> (8 * off)) & 32'h000000FF;
          rd = (u || v < 32'd128) ? v : (v | 32'hFFFFFF00);
        end else if (sz == 2'd1) begin
          v  = (word >> (8 * off)) & 32'h0000FFFF;
          rd = (u || v < 32'd32768) ? v : (v | 32'hFFFF0000);
        end else begin
          rd = word;
        end
      end
    end
  endfunction

  task automatic xact(input logic w, input logic [1:0] sz, input logic u, input logic [31:0] a,
                      input logic [31:0] wd, input bit toggle,
                      output logic [31:0] rd, output logic er,
                      output int nready, output int lat, output int nbusy);
    rd = 32'd0; er = 1'b0; nready = 0; lat = -1; nbusy = 0;
    @(negedge clk);
    req = 1'b1; we = w; size = sz; unsigned_ld = u; address = a; write_data = wd;
    #1;
    for (int c = 0; c < WC + 6; c++) begin
      if (c > 0) begin
        @(posedge clk);
        #1;
        if (toggle && nready == 0) begin
          req = 1'($urandom); we = 1'($urandom);
          address = $urandom; write_data = $urandom;
        end else begin
          req = 1'b0;
        end
        #1;
      end
      if (busy) nbusy++;
      if (ready) begin
        nready++;
        if (lat < 0) lat = c;
        rd = read_data;
        er = error;
      end
    end
    req = 1'b0;
  endtask

  task automatic run(input string tag, input logic w, input logic [1:0] sz, input logic u,
                     input logic [31:0] a, input logic [31:0] wd, input bit toggle);
    logic [31:0] rd, exp_rd;
    logic        er, exp_er;
    int          nready, lat, nbusy;
    xact(w, sz, u, a, wd, toggle, rd, er, nready, lat, nbusy);
    ref_access(w, sz, u, a, wd, exp_rd, exp_er);
    check({tag, "_nready"}, 32'(nready), 32'd1);
    check({tag, "_lat"}, 32'(lat), 32'(WC + 2));
    check({tag, "_busy"}, 32'(nbusy), 32'(WC + 2));
    check({tag, "_rd"}, rd, exp_rd);
    check({tag, "_err"}, {31'd0, er}, {31'd0, exp_er});
    last_rd = rd;
    last_er = er;
  endtask

  initial begin
    int          nready;
    bit          found;
    logic [31:0] a;
    reset = 1'b0; req = 1'b0; we = 1'b0; size = 2'b00; unsigned_ld = 1'b0;
    address = 32'd0; write_data = 32'd0;
    last_rd = 32'd0; last_er = 1'b0;

    // Step 1: reset and release.
    repeat (3) @(posedge clk);
    #1;
    check("rst_ready", {31'd0, ready}, 32'd0);
    check("rst_rdata", read_data, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    #1;
    check("rel_ready", {31'd0, ready}, 32'd0);
    check("rel_error", {31'd0, error}, 32'd0);
    check("rel_busy", {31'd0, busy}, 32'd0);
    check("rel_rdata", read_data, 32'd0);
    req = 1'b1;
    #1;
    check("busy_follows_req", {31'd0, busy}, 32'd1);
    req = 1'b0;
    #1;

    // Known contents for the first 32 words.
    for (int i = 0; i < 32; i++) run("fill", 1'b1, 2'd2, 1'b0, 32'(i * 4), $urandom, 1'b0);

    // Step 2: word store and load.
    run("sw40", 1'b1, 2'd2, 1'b0, 32'h40, 32'hDEADBEEF, 1'b0);
    run("lw40", 1'b0, 2'd2, 1'b0, 32'h40, 32'd0, 1'b0);
    check("lw40_const", last_rd, 32'hDEADBEEF);

    // Step 3: sub-word accesses.
    run("sb41", 1'b1, 2'd0, 1'b0, 32'h41, 32'h12345680, 1'b0);
    run("lb41", 1'b0, 2'd0, 1'b0, 32'h41, 32'd0, 1'b0);
    check("lb41_const", last_rd, 32'hFFFFFF80);
    run("lbu41", 1'b0, 2'd0, 1'b1, 32'h41, 32'd0, 1'b0);
    check("lbu41_const", last_rd, 32'h00000080);
    run("lh42", 1'b0, 2'd1, 1'b0, 32'h42, 32'd0, 1'b0);
    check("lh42_const", last_rd, 32'hFFFFDEAD);
    run("lw40b", 1'b0, 2'd2, 1'b0, 32'h40, 32'd0, 1'b0);
    check("lw40b_const", last_rd, 32'hDEAD80EF);

    // Step 4: misaligned and illegal accesses.
    run("lw42", 1'b0, 2'd2, 1'b0, 32'h42, 32'd0, 1'b0);
    check("lw42_err_const", {31'd0, last_er}, 32'd1);
    run("sh43", 1'b1, 2'd1, 1'b0, 32'h43, 32'h5555AAAA, 1'b0);
    check("sh43_err_const", {31'd0, last_er}, 32'd1);
    run("sz3", 1'b1, 2'd3, 1'b0, 32'h40, 32'h77777777, 1'b0);
    check("sz3_err_const", {31'd0, last_er}, 32'd1);
    check("sz3_rd_const", last_rd, 32'd0);
    run("lw40c", 1'b0, 2'd2, 1'b0, 32'h40, 32'd0, 1'b0);
    check("lw40c_const", last_rd, 32'hDEAD80EF);

    // Step 5: reset during WAIT aborts the store.
    @(negedge clk);
    req = 1'b1; we = 1'b1; size = 2'd2; address = 32'h40; write_data = 32'h11111111;
    @(posedge clk);
    #1;
    req = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b0;
    #1;
    check("abort_ready", {31'd0, ready}, 32'd0);
    check("abort_busy", {31'd0, busy}, 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    nready = 0;
    for (int c = 0; c < WC + 6; c++) begin
      @(negedge clk);
      if (ready) nready++;
    end
    check("abort_no_ready", 32'(nready), 32'd0);
    run("lw40d", 1'b0, 2'd2, 1'b0, 32'h40, 32'd0, 1'b0);
    check("lw40d_const", last_rd, 32'hDEAD80EF);

    // Reset in RESP clears ready at once.
    @(negedge clk);
    req = 1'b1; we = 1'b0; size = 2'd2; address = 32'h40;
    @(posedge clk);
    #1;
    req = 1'b0;
    found = 1'b0;
    for (int c = 0; c < 10 && !found; c++) begin
      @(posedge clk);
      #1;
      if (ready) found = 1'b1;
    end
    check("resp_found", {31'd0, found}, 32'd1);
    reset = 1'b0;
    #1;
    check("resp_rst_ready", {31'd0, ready}, 32'd0);
    check("resp_rst_rdata", read_data, 32'd0);
    @(negedge clk);
    reset = 1'b1;

    // Step 6: address aliasing, req toggling during WAIT.
    run("sw1000", 1'b1, 2'd2, 1'b0, 32'h1000, 32'hCAFEF00D, 1'b1);
    run("lw0000", 1'b0, 2'd2, 1'b0, 32'h0000, 32'd0, 1'b1);
    check("lw0000_const", last_rd, 32'hCAFEF00D);

    // Randomized accesses in the initialized window with random alias bits.
    for (int i = 0; i < 40; i++) begin
      a = ($urandom & 32'hFFFFF000) | 32'($urandom_range(0, 127));
      run("rnd", 1'($urandom), 2'($urandom), 1'($urandom), a, $urandom, 1'($urandom));
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/data_memory_responder.md
# data_memory_responder

Multi-cycle data-memory responder that serves the memory stage of the pipelined RISC-V core. It accepts one load/store request at a time from the M stage and inserts a configurable number of wait states. It raises a stall toward the hazard unit while the access is in flight, then returns sign/zero-extended load data with a one-cycle `ready` pulse. It replaces the zero-latency data memory so the pipeline's stall path is exercised against a realistic responder.

## Interface
Parameters:
- `ADDR_WIDTH`, 10: log2 of word count; array is 2^ADDR_WIDTH 32-bit words.
- `WAIT_CYCLES`, 2: wait states before the access edge; legal range 0..15.

Ports:
- `clk`  in  1  single clock; all state updates on rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `req`  in  1  request valid from M stage; sampled only in IDLE.
- `we`  in  1  1 = store, 0 = load.
- `size`  in  2  00 byte, 01 half, 10 word, 11 illegal.
- `unsigned_ld`  in  1  1 = zero-extend load, 0 = sign-extend.
- `address`  in  32  byte address (ALUResultM).
- `write_data`  in  32  store data (WriteDataM); low byte/half used for sub-word stores.
- `read_data`  out  32  load result, valid while `ready`=1.
- `ready`  out  1  one-cycle completion pulse.
- `error`  out  1  misaligned/illegal access flag, valid with `ready`.
- `busy`  out  1  stall request to hazard unit (combinational).

## Operation
- FSM states are IDLE, WAIT and RESP, with a 4-bit down-counter `cnt`.
- IDLE with `req`=1: latch `we`, `size`, `unsigned_ld`, `address`, `write_data`; load `cnt`=WAIT_CYCLES; go to WAIT. With `req`=0 stay in IDLE.
- WAIT with `cnt`≠0: decrement `cnt`.
- WAIT with `cnt`=0: perform the access at this edge, go to RESP.
- RESP: `ready`=1 for exactly this cycle; next edge goes to IDLE unconditionally. `req` is ignored in WAIT and RESP.
- `busy` = (IDLE & `req`) | WAIT. It is 0 in RESP so the pipeline advances in the `ready` cycle.
- Word index = `address[ADDR_WIDTH+1:2]`. Upper address bits are ignored, so addresses alias (wrap) modulo 2^(ADDR_WIDTH+2).
- Misaligned condition:
  - half with `address[0]`=1, or
  - word with `address[1:0]`≠00, or
  - `size`=11.
  - On misaligned: no array write, `read_data`=0, `error`=1 in RESP.
- Store: write only the addressed byte lanes. Byte uses lane `address[1:0]` with `write_data[7:0]`. Half uses lanes {`address[1]`,x} with `write_data[15:0]`. Word writes all lanes. Other lanes are preserved. `read_data`=0 on stores.
- Load: select the byte/half from the addressed word, then extend per `unsigned_ld`. Word loads ignore `unsigned_ld`. The result is registered into `read_data` at the access edge.
- Array contents are not reset.

## Timing
- Reset (asynchronous, `reset`=0) forces: state IDLE, `cnt`=0, `ready`=0, `error`=0, `read_data`=0, latched request cleared. `busy` follows `req` immediately after release.
- Latency: with accept at edge k, the access happens at edge k+WAIT_CYCLES+1. `ready` is high between edges k+WAIT_CYCLES+1 and k+WAIT_CYCLES+2.
- WAIT_CYCLES=0 gives accept → WAIT with `cnt`=0 → access next edge, so `ready` comes one cycle after accept.
- Minimum request spacing is WAIT_CYCLES+3 cycles. A new request is accepted on the first IDLE cycle after RESP.
- Reset asserted in WAIT aborts the access: no array write, no `ready` pulse. Reset in RESP clears `ready` immediately.
- Changes on `req`/`address`/`write_data` after acceptance have no effect on the in-flight access.

## Test plan
1. Hold `reset`=0 for 3 cycles, then release with `req`=0 → `ready`=0, `error`=0, `busy`=0, `read_data`=0x00000000.
2. Word store 0xDEADBEEF @0x40, then word load @0x40 (WAIT_CYCLES=2) → `busy`=1 for the accept cycle plus 2 WAIT cycles plus the access cycle. `ready` pulses once with `read_data`=0xDEADBEEF.
3. After test 2: byte store 0x80 @0x41 → lb @0x41 returns 0xFFFFFF80; lbu @0x41 returns 0x00000080; lh @0x42 returns 0xFFFFDEAD; lw @0x40 returns 0xDEAD80EF.
4. lw @0x42, sh @0x43 and `size`=11 @0x40 → each gives `error`=1 with `ready` and `read_data`=0. A subsequent lw @0x40 still returns 0xDEAD80EF.
5. Word store 0x11111111 @0x40, with `reset` pulsed low during WAIT → no `ready`. After release, lw @0x40 returns the previous value 0xDEAD80EF.
6. ADDR_WIDTH=10: word store 0xCAFEF00D @0x1000, then lw @0x0000 → 0xCAFEF00D (wrap/alias). `req` toggled during WAIT is ignored, so exactly one `ready` pulse per accepted request.
